// File: rtl/fft_cbfp_norm.sv
// rtl/fft_cbfp_norm.sv - CBFP group buffer with shift-count normalization
module fft_cbfp_norm #(
  parameter int ARRAY_SIZE     = 16,
  parameter int DIN_SIZE       = 23,
  parameter int DOUT_SIZE      = 11,
  parameter int CNT_SIZE       = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int GROUPS_PER_BLK = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     valid_in,
  input  logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]      din_re,
  input  logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]      din_im,
  input  logic                                     cnt_valid,
  input  logic [CNT_SIZE-1:0]                      cnt_in,
  input  logic                                     err_clr,
  output logic                                     valid_out,
  output logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0]     dout_re,
  output logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0]     dout_im,
  output logic [CNT_SIZE-1:0]                      exp_out,
  output logic [$clog2(GROUPS_PER_BLK)-1:0]        grp_idx,
  output logic                                     blk_last,
  output logic                                     ovf_err,
  output logic                                     udf_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = $clog2(GROUPS_PER_BLK);

  typedef logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]  grp_in_t;
  typedef logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0] grp_out_t;

  grp_in_t               mem_re_q [FIFO_DEPTH];
  grp_in_t               mem_im_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [GW-1:0]         grp_cnt_q, grp_cnt_d;
  logic                  valid_q;
  grp_out_t              dout_re_q, dout_im_q;
  grp_out_t              norm_re_d, norm_im_d;
  logic [CNT_SIZE-1:0]   exp_q, shift_d;
  logic [GW-1:0]         grp_idx_q;
  logic                  blk_last_q;
  logic                  ovf_q, udf_q;
  logic                  full, empty, pop, push, ovf_set, udf_set;
  logic [DIN_SIZE-1:0]   sh_re, sh_im;

  assign full    = (occ_q == OW'(FIFO_DEPTH));
  assign empty   = (occ_q == '0);
  // A pop never bypasses: an empty FIFO ignores the count even if a push lands this cycle.
  assign pop     = cnt_valid & ~empty;
  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign push    = valid_in & (~full | pop);
  assign ovf_set = valid_in & full & ~pop;
  assign udf_set = cnt_valid & empty;

  // Shift is clamped so a sample can never be shifted entirely out of range.
  assign shift_d = (32'(cnt_in) > 32'(DIN_SIZE - 1)) ? CNT_SIZE'(DIN_SIZE - 1) : cnt_in;

  // Pointer wrap and occupancy tracking
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  // Normalize the oldest entry: left shift, keep the top DOUT_SIZE bits (truncate)
  always_comb begin
    norm_re_d = '0;
    norm_im_d = '0;
    sh_re     = '0;
    sh_im     = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      sh_re        = mem_re_q[rd_ptr_q][i] << shift_d;
      sh_im        = mem_im_q[rd_ptr_q][i] << shift_d;
      norm_re_d[i] = sh_re[DIN_SIZE-1 -: DOUT_SIZE];
      norm_im_d[i] = sh_im[DIN_SIZE-1 -: DOUT_SIZE];
    end
  end

  // Group position wraps at the block boundary
  always_comb begin
    grp_cnt_d = grp_cnt_q;
    if (pop) grp_cnt_d = (grp_cnt_q == GW'(GROUPS_PER_BLK - 1)) ? '0 : grp_cnt_q + 1'b1;
  end

  // FIFO storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_re_q[wr_ptr_q] <= din_re;
      mem_im_q[wr_ptr_q] <= din_im;
    end
  end

  // Control state, registered outputs and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      grp_cnt_q  <= '0;
      valid_q    <= 1'b0;
      dout_re_q  <= '0;
      dout_im_q  <= '0;
      exp_q      <= '0;
      grp_idx_q  <= '0;
      blk_last_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      grp_cnt_q <= grp_cnt_d;
      valid_q   <= pop;
      if (pop) begin
        dout_re_q  <= norm_re_d;
        dout_im_q  <= norm_im_d;
        exp_q      <= shift_d;
        grp_idx_q  <= grp_cnt_q;
        blk_last_q <= (grp_cnt_q == GW'(GROUPS_PER_BLK - 1));
      end
      ovf_q <= ovf_set | (ovf_q & ~err_clr);
      udf_q <= udf_set | (udf_q & ~err_clr);
    end
  end

  assign valid_out = valid_q;
  assign dout_re   = dout_re_q;
  assign dout_im   = dout_im_q;
  assign exp_out   = exp_q;
  assign grp_idx   = grp_idx_q;
  assign blk_last  = blk_last_q;
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;

endmodule

// File: tb/tb_fft_cbfp_norm.sv
// tb/tb_fft_cbfp_norm.sv - randomized self-checking bench for fft_cbfp_norm
module tb_fft_cbfp_norm;
  localparam int A = 16, D = 23, O = 11, C = 5, F = 4, G = 4;

  typedef logic [A-1:0][D-1:0] grp_t;
  typedef logic [A-1:0][O-1:0] ogrp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_in = 1'b0;
  grp_t         din_re = '0, din_im = '0;
  logic         cnt_valid = 1'b0;
  logic [C-1:0] cnt_in = '0;
  logic         err_clr = 1'b0;
  logic         valid_out, blk_last, ovf_err, udf_err;
  ogrp_t        dout_re, dout_im;
  logic [C-1:0] exp_out;
  logic [1:0]   grp_idx;

  fft_cbfp_norm #(.ARRAY_SIZE(A), .DIN_SIZE(D), .DOUT_SIZE(O), .CNT_SIZE(C),
                  .FIFO_DEPTH(F), .GROUPS_PER_BLK(G)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din_re(din_re), .din_im(din_im),
    .cnt_valid(cnt_valid), .cnt_in(cnt_in), .err_clr(err_clr),
    .valid_out(valid_out), .dout_re(dout_re), .dout_im(dout_im), .exp_out(exp_out),
    .grp_idx(grp_idx), .blk_last(blk_last), .ovf_err(ovf_err), .udf_err(udf_err));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  grp_t         mq_re[$], mq_im[$];
  int           gcnt;
  logic         e_valid, e_blk, e_ovf, e_udf;
  logic [C-1:0] e_exp;
  logic [1:0]   e_grp;
  ogrp_t        e_dre, e_dim;

  function automatic grp_t rand_grp();
    grp_t g;
    for (int i = 0; i < A; i++) g[i] = D'($urandom);
    return g;
  endfunction

  function automatic grp_t fill_grp(logic [D-1:0] x);
    grp_t g;
    for (int i = 0; i < A; i++) g[i] = x;
    return g;
  endfunction

  // value * 2^s, wrapped into a D-bit word, then the top O bits of that word
  function automatic ogrp_t norm_grp(grp_t g, int s);
    ogrp_t o;
    longint v, wrapped;
    for (int i = 0; i < A; i++) begin
      v       = longint'($signed(g[i])) * (longint'(1) << s);
      wrapped = v & ((longint'(1) << D) - 1);
      o[i]    = O'(wrapped / (longint'(1) << (D - O)));
    end
    return o;
  endfunction

  function automatic logic [C+5:0] e_ctl();
    return {e_valid, e_exp, e_grp, e_blk, e_ovf, e_udf};
  endfunction

  task automatic model_reset();
    mq_re.delete(); mq_im.delete();
    gcnt = 0;
    e_valid = 0; e_blk = 0; e_ovf = 0; e_udf = 0; e_exp = '0; e_grp = '0;
    e_dre = '0; e_dim = '0;
  endtask

  // apply one cycle of inputs, advance the model, sample 1ns after the edge
  task automatic drive_cycle(input logic v, input grp_t re, input grp_t im,
                             input logic cv, input logic [C-1:0] cnt, input logic clr);
    bit full, do_pop;
    int s;
    valid_in = v; din_re = re; din_im = im; cnt_valid = cv; cnt_in = cnt; err_clr = clr;
    full   = (mq_re.size() == F);
    do_pop = cv && (mq_re.size() > 0);
    e_ovf  = (v && full && !do_pop) ? 1'b1 : (clr ? 1'b0 : e_ovf);
    e_udf  = (cv && mq_re.size() == 0) ? 1'b1 : (clr ? 1'b0 : e_udf);
    e_valid = do_pop;
    if (do_pop) begin
      s      = (int'(cnt) > D - 1) ? D - 1 : int'(cnt);
      e_dre  = norm_grp(mq_re.pop_front(), s);
      e_dim  = norm_grp(mq_im.pop_front(), s);
      e_exp  = C'(s);
      e_grp  = 2'(gcnt);
      e_blk  = (gcnt == G - 1);
      gcnt   = (gcnt + 1) % G;
    end
    if (v && (!full || do_pop)) begin
      mq_re.push_back(re);
      mq_im.push_back(im);
    end
    @(posedge clk); #1;
    valid_in = 0; cnt_valid = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++;
    if ({valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err} !== e_ctl()) begin
      bad++; $display("FAIL reset_ctl got %h want %h",
                      {valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err}, e_ctl());
    end
    total++;
    if (dout_re !== '0 || dout_im !== '0) begin
      bad++; $display("FAIL reset_dout got %h/%h want 0", dout_re, dout_im);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    drive_cycle(1, fill_grp(23'h000400), rand_grp(), 0, '0, 0);
    drive_cycle(0, '0, '0, 1, 5'd10, 0);
    total++;
    if ({valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err} !== e_ctl()) begin
      bad++; $display("FAIL basic_ctl got %h want %h",
                      {valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err}, e_ctl());
    end
    total++;
    if (dout_re !== e_dre || dout_im !== e_dim) begin
      bad++; $display("FAIL basic_dout got %h want %h", dout_re, e_dre);
    end
    drive_cycle(0, '0, '0, 0, '0, 0);
    total++;
    if (valid_out !== 1'b0 || dout_re !== e_dre || exp_out !== e_exp) begin
      bad++; $display("FAIL basic_hold got v=%b exp=%0d want v=0 exp=%0d", valid_out, exp_out, e_exp);
    end
  endtask

  task automatic test_block_order();
    for (int i = 0; i < 3; i++) drive_cycle(1, rand_grp(), rand_grp(), 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(i == 0, rand_grp(), rand_grp(), 1, C'($urandom_range(0, 31)), 0);
      total++;
      if ({valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err} !== e_ctl()) begin
        bad++; $display("FAIL block_ctl[%0d] got %h want %h", i,
                        {valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err}, e_ctl());
      end
      total++;
      if (dout_re !== e_dre || dout_im !== e_dim) begin
        bad++; $display("FAIL block_dout[%0d] got %h want %h", i, dout_re, e_dre);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) drive_cycle(1, fill_grp(D'(i + 1) << 4), rand_grp(), 0, '0, 0);
    total++;
    if (ovf_err !== 1'b1 || e_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_set got %b want 1", ovf_err);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, '0, '0, 1, 5'd0, 0);
      total++;
      if (valid_out !== 1'b1 || dout_re !== e_dre || dout_re[0] !== O'(0)) begin
        bad++; $display("FAIL ovf_pop[%0d] got %h want %h", i, dout_re, e_dre);
      end
    end
    drive_cycle(0, '0, '0, 0, '0, 1);
    total++;
    if (ovf_err !== 1'b0) begin
      bad++; $display("FAIL ovf_clr got %b want 0", ovf_err);
    end
  endtask

  task automatic test_underflow_full();
    drive_cycle(1, rand_grp(), rand_grp(), 1, 5'd3, 0);
    total++;
    if (valid_out !== 1'b0 || udf_err !== 1'b1) begin
      bad++; $display("FAIL udf got v=%b udf=%b want v=0 udf=1", valid_out, udf_err);
    end
    drive_cycle(0, '0, '0, 0, '0, 1);
    for (int i = 0; i < 3; i++) drive_cycle(1, rand_grp(), rand_grp(), 0, '0, 0);
    drive_cycle(1, rand_grp(), rand_grp(), 1, 5'd7, 0);
    total++;
    if ({valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err} !== e_ctl() || ovf_err !== 1'b0) begin
      bad++; $display("FAIL full_pushpop got %h want %h",
                      {valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err}, e_ctl());
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, '0, '0, 1, C'($urandom_range(0, 31)), 0);
      total++;
      if ({valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err} !== e_ctl() ||
          dout_re !== e_dre || dout_im !== e_dim) begin
        bad++; $display("FAIL drain[%0d] got %h want %h", i,
                        {valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err}, e_ctl());
      end
    end
    drive_cycle(0, '0, '0, 0, '0, 1);
  endtask

  task automatic test_extremes();
    drive_cycle(1, fill_grp('1), fill_grp(23'h400000), 0, '0, 0);
    drive_cycle(0, '0, '0, 1, 5'd31, 0);
    total++;
    if (exp_out !== 5'd22 || dout_re !== e_dre || dout_im !== e_dim) begin
      bad++; $display("FAIL clamp got exp=%0d re=%h want exp=22 re=%h", exp_out, dout_re, e_dre);
    end
    drive_cycle(1, fill_grp(23'h400000), fill_grp(23'h3fffff), 0, '0, 0);
    drive_cycle(0, '0, '0, 1, 5'd0, 0);
    total++;
    if (dout_re[3] !== 11'h400 || dout_re !== e_dre || dout_im !== e_dim) begin
      bad++; $display("FAIL noshift got %h want %h", dout_re, e_dre);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_cycle(($urandom % 2) == 0, rand_grp(), rand_grp(), ($urandom % 3) == 0,
                  C'($urandom_range(0, 31)), ($urandom % 16) == 0);
      total++;
      if ({valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err} !== e_ctl() ||
          dout_re !== e_dre || dout_im !== e_dim) begin
        bad++; $display("FAIL random[%0d] got %h want %h", n,
                        {valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err}, e_ctl());
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(0, '0, '0, 0, '0, 1);
    while (mq_re.size() > 0) drive_cycle(0, '0, '0, 1, 5'd1, 0);
    for (int i = 0; i < 4; i++) drive_cycle(1, rand_grp(), rand_grp(), 0, '0, 0);
    drive_cycle(0, '0, '0, 1, 5'd4, 0);
    #2 rst = 1;
    #1;
    model_reset();
    total++;
    if ({valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err} !== e_ctl() ||
        dout_re !== '0 || dout_im !== '0) begin
      bad++; $display("FAIL async_rst got %h want %h",
                      {valid_out, exp_out, grp_idx, blk_last, ovf_err, udf_err}, e_ctl());
    end
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
    drive_cycle(0, '0, '0, 1, 5'd2, 0);
    total++;
    if (valid_out !== 1'b0 || udf_err !== 1'b1) begin
      bad++; $display("FAIL post_rst_udf got v=%b udf=%b want v=0 udf=1", valid_out, udf_err);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_block_order();
    test_overflow();
    test_underflow_full();
    test_extremes();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
